control_unit: RTL and testbench

// - Main decoder for the single-cycle RV64I core. Maps opcode/funct3/funct7[30] to

---
 rtl/control_unit_pkg.sv | 43 ++++
 rtl/control_unit_branch_resolver.sv | 31 +++
 rtl/control_unit.sv | 114 +++++++++++
 tb/tb_control_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared encodings for the RV64I main decoder: opcodes, ALU operation codes
// and datapath mux select values.
package control_unit_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/control_unit_branch_resolver.sv
// Branch condition evaluation from the flags of the SUB performed this cycle.
module branch_resolver
    import control_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       negative,
    input  logic       carry,
    input  logic       overflow,
    output logic       take
);

    logic signed_lt;

    // Carry is "no borrow", so unsigned A<B is its complement.
    assign signed_lt = negative ^ overflow;

    always_comb begin
        take = 1'b0;
        case (funct3)
            F3_BEQ:  take = zero;
            F3_BNE:  take = ~zero;
            F3_BLT:  take = signed_lt;
            F3_BGE:  take = ~signed_lt;
            F3_BLTU: take = ~carry;
            F3_BGEU: take = carry;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main decoder for the single-cycle RV64I core; purely combinational, clk and
// reset exist only for interface uniformity with the rest of the core.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       Zero,
    input  logic       Negative,
    input  logic       Carry,
    input  logic       Overflow,
    input  logic       funct7,
    input  logic [2:0] funct3,
    input  logic [6:0] opcode,
    output logic       regWriteEnable,
    output logic       load,
    output logic       store,
    output logic       word,
    output logic [3:0] ALUControl,
    output logic       JALR,
    output logic       sel_mux_pcnext,
    output logic       sel_mux_srcB,
    output logic [1:0] sel_mux_srcA,
    output logic [1:0] sel_mux_writeback
);

    logic branch_take;
    logic f7b_reg_op;
    logic f7b_imm_op;
    logic unused_inputs;

    assign unused_inputs = &{1'b0, clk, reset};

    branch_resolver u_branch_resolver (
        .funct3   (funct3),
        .zero     (Zero),
        .negative (Negative),
        .carry    (Carry),
        .overflow (Overflow),
        .take     (branch_take)
    );

    // Register ops use bit 30 for SUB and SRA; immediate ops only for SRAI,
    // since an ADDI immediate may legitimately have bit 30 set.
    assign f7b_reg_op = funct7 & ((funct3 == 3'b000) || (funct3 == 3'b101));
    assign f7b_imm_op = funct7 & (funct3 == 3'b101);

    always_comb begin
        regWriteEnable    = 1'b0;
        load              = 1'b0;
        store             = 1'b0;
        word              = 1'b0;
        ALUControl        = ALU_ADD;
        JALR              = 1'b0;
        sel_mux_pcnext    = 1'b0;
        sel_mux_srcB      = 1'b0;
        sel_mux_srcA      = SRCA_RS1;
        sel_mux_writeback = WB_ALU;

        case (opcode)
            OPC_OP, OPC_OP_32: begin
                regWriteEnable = 1'b1;
                word           = (opcode == OPC_OP_32);
                ALUControl     = {f7b_reg_op, funct3};
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                regWriteEnable = 1'b1;
                sel_mux_srcB   = 1'b1;
                word           = (opcode == OPC_OP_IMM_32);
                ALUControl     = {f7b_imm_op, funct3};
            end
            OPC_LOAD: begin
                regWriteEnable    = 1'b1;
                load              = 1'b1;
                sel_mux_srcB      = 1'b1;
                sel_mux_writeback = WB_MEM;
            end
            OPC_STORE: begin
                store        = 1'b1;
                sel_mux_srcB = 1'b1;
            end
            OPC_LUI: begin
                regWriteEnable = 1'b1;
                sel_mux_srcB   = 1'b1;
                sel_mux_srcA   = SRCA_ZERO;
            end
            OPC_AUIPC: begin
                regWriteEnable = 1'b1;
                sel_mux_srcB   = 1'b1;
                sel_mux_srcA   = SRCA_PC;
            end
            OPC_JAL: begin
                regWriteEnable    = 1'b1;
                sel_mux_pcnext    = 1'b1;
                sel_mux_srcB      = 1'b1;
                sel_mux_srcA      = SRCA_PC;
                sel_mux_writeback = WB_PC4;
            end
            OPC_JALR: begin
                regWriteEnable    = 1'b1;
                JALR              = 1'b1;
                sel_mux_pcnext    = 1'b1;
                sel_mux_srcB      = 1'b1;
                sel_mux_writeback = WB_PC4;
            end
            OPC_BRANCH: begin
                ALUControl     = ALU_SUB;
                sel_mux_pcnext = branch_take;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit; expected control words are hand-coded.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic       Zero, Negative, Carry, Overflow;
    logic       funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
    logic       regWriteEnable, load, store, word, JALR;
    logic [3:0] ALUControl;
    logic       sel_mux_pcnext, sel_mux_srcB;
    logic [1:0] sel_mux_srcA, sel_mux_writeback;

    int checks = 0;
    int failures = 0;

    control_unit dut (
        .clk               (clk),
        .reset             (reset),
        .Zero              (Zero),
        .Negative          (Negative),
        .Carry             (Carry),
        .Overflow          (Overflow),
        .funct7            (funct7),
        .funct3            (funct3),
        .opcode            (opcode),
        .regWriteEnable    (regWriteEnable),
        .load              (load),
        .store             (store),
        .word              (word),
        .ALUControl        (ALUControl),
        .JALR              (JALR),
        .sel_mux_pcnext    (sel_mux_pcnext),
        .sel_mux_srcB      (sel_mux_srcB),
        .sel_mux_srcA      (sel_mux_srcA),
        .sel_mux_writeback (sel_mux_writeback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control word: regW load store word ALU[3:0] JALR pcnext srcB srcA[1:0] wb[1:0]
    function automatic logic [14:0] cw(input logic rw, input logic ld, input logic st,
                                       input logic wd, input logic [3:0] alu,
                                       input logic jr, input logic pc, input logic sb,
                                       input logic [1:0] sa, input logic [1:0] wb);
        return {rw, ld, st, wd, alu, jr, pc, sb, sa, wb};
    endfunction

    task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic [3:0] zncv, input logic [14:0] exp_cw);
        logic [14:0] obs;
        @(negedge clk);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        {Zero, Negative, Carry, Overflow} = zncv;
        #1;
        obs = {regWriteEnable, load, store, word, ALUControl, JALR, sel_mux_pcnext,
               sel_mux_srcB, sel_mux_srcA, sel_mux_writeback};
        checks++;
        assert (obs === exp_cw) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_cw);
        end
        $display("step %-12s op=%b f3=%b f7=%b zncv=%b cw=%h", tag, op, f3, f7, zncv, obs);
    endtask

    initial begin
        reset = 1'b1;
        opcode = '0; funct3 = '0; funct7 = 1'b0;
        {Zero, Negative, Carry, Overflow} = 4'b0000;

        step("reset_zero",  7'b0000000, 3'b000, 1'b0, 4'b0000, cw(0,0,0,0,4'b0000,0,0,0,2'b00,2'b00));
        step("reset_op",    7'b0110011, 3'b000, 1'b1, 4'b0000, cw(1,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        @(negedge clk);
        reset = 1'b0;

        step("op_sub",      7'b0110011, 3'b000, 1'b1, 4'b0000, cw(1,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        step("op_sra",      7'b0110011, 3'b101, 1'b1, 4'b0000, cw(1,0,0,0,4'b1101,0,0,0,2'b00,2'b00));
        step("op_and_f7",   7'b0110011, 3'b111, 1'b1, 4'b1111, cw(1,0,0,0,4'b0111,0,0,0,2'b00,2'b00));
        step("op_add",      7'b0110011, 3'b000, 1'b0, 4'b0000, cw(1,0,0,0,4'b0000,0,0,0,2'b00,2'b00));
        step("addi_f7",     7'b0010011, 3'b000, 1'b1, 4'b0000, cw(1,0,0,0,4'b0000,0,0,1,2'b00,2'b00));
        step("srai",        7'b0010011, 3'b101, 1'b1, 4'b0000, cw(1,0,0,0,4'b1101,0,0,1,2'b00,2'b00));
        step("slli",        7'b0010011, 3'b001, 1'b1, 4'b0000, cw(1,0,0,0,4'b0001,0,0,1,2'b00,2'b00));
        step("subw",        7'b0111011, 3'b000, 1'b1, 4'b0000, cw(1,0,0,1,4'b1000,0,0,0,2'b00,2'b00));
        step("sraiw",       7'b0011011, 3'b101, 1'b1, 4'b0000, cw(1,0,0,1,4'b1101,0,0,1,2'b00,2'b00));
        step("addiw_f7",    7'b0011011, 3'b000, 1'b1, 4'b0000, cw(1,0,0,1,4'b0000,0,0,1,2'b00,2'b00));
        step("load",        7'b0000011, 3'b011, 1'b0, 4'b0000, cw(1,1,0,0,4'b0000,0,0,1,2'b00,2'b01));
        step("store",       7'b0100011, 3'b011, 1'b1, 4'b1000, cw(0,0,1,0,4'b0000,0,0,1,2'b00,2'b00));
        step("lui",         7'b0110111, 3'b101, 1'b1, 4'b0000, cw(1,0,0,0,4'b0000,0,0,1,2'b10,2'b00));
        step("auipc",       7'b0010111, 3'b000, 1'b0, 4'b0000, cw(1,0,0,0,4'b0000,0,0,1,2'b01,2'b00));
        step("jal",         7'b1101111, 3'b000, 1'b0, 4'b1000, cw(1,0,0,0,4'b0000,0,1,1,2'b01,2'b10));
        step("jalr",        7'b1100111, 3'b000, 1'b0, 4'b0000, cw(1,0,0,0,4'b0000,1,1,1,2'b00,2'b10));
        step("beq_z1",      7'b1100011, 3'b000, 1'b0, 4'b1000, cw(0,0,0,0,4'b1000,0,1,0,2'b00,2'b00));
        step("beq_z0",      7'b1100011, 3'b000, 1'b0, 4'b0000, cw(0,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        step("bne_z0",      7'b1100011, 3'b001, 1'b0, 4'b0000, cw(0,0,0,0,4'b1000,0,1,0,2'b00,2'b00));
        step("bne_z1",      7'b1100011, 3'b001, 1'b0, 4'b1000, cw(0,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        step("blt_n1v0",    7'b1100011, 3'b100, 1'b0, 4'b0100, cw(0,0,0,0,4'b1000,0,1,0,2'b00,2'b00));
        step("blt_n0v0",    7'b1100011, 3'b100, 1'b0, 4'b0000, cw(0,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        step("blt_n1v1",    7'b1100011, 3'b100, 1'b0, 4'b0101, cw(0,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        step("bge_n0v0",    7'b1100011, 3'b101, 1'b1, 4'b0000, cw(0,0,0,0,4'b1000,0,1,0,2'b00,2'b00));
        step("bge_n0v1",    7'b1100011, 3'b101, 1'b0, 4'b0001, cw(0,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        step("bltu_c0",     7'b1100011, 3'b110, 1'b0, 4'b0000, cw(0,0,0,0,4'b1000,0,1,0,2'b00,2'b00));
        step("bltu_c1",     7'b1100011, 3'b110, 1'b0, 4'b0010, cw(0,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        step("bgeu_c1",     7'b1100011, 3'b111, 1'b0, 4'b0010, cw(0,0,0,0,4'b1000,0,1,0,2'b00,2'b00));
        step("bgeu_c0",     7'b1100011, 3'b111, 1'b0, 4'b0000, cw(0,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        step("br_f3_010",   7'b1100011, 3'b010, 1'b0, 4'b1111, cw(0,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        step("br_f3_011",   7'b1100011, 3'b011, 1'b0, 4'b1010, cw(0,0,0,0,4'b1000,0,0,0,2'b00,2'b00));
        step("unknown_op",  7'b1111111, 3'b101, 1'b1, 4'b1111, cw(0,0,0,0,4'b0000,0,0,0,2'b00,2'b00));
        step("op_flags",    7'b0110011, 3'b100, 1'b0, 4'b1111, cw(1,0,0,0,4'b0100,0,0,0,2'b00,2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
